lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/gpu_pkg.sv | 19 +
 rtl/lsu_watchdog.sv | 43 ++++
 rtl/lsu.sv | 135 +++++++++++++
 tb/tb_lsu.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpu_pkg : shared LSU state encoding and default memory widths            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gpu_pkg;

  localparam int LSU_ADDR_WIDTH = 8;
  localparam int LSU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_REQUEST = 2'd1,
    LSU_WAITING = 2'd2,
    LSU_DONE    = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_watchdog : WAITING-cycle counter, built only with LSU_TIMEOUT_EN     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifdef LSU_TIMEOUT_EN
module lsu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the WAITING cycle whose increment brings the count to the limit.
  assign expired = count && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu : single-thread load/store unit, IDLE/REQUEST/WAITING/DONE sequencer |
// | Optional watchdog with `define LSU_TIMEOUT_EN.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
module lsu
  import gpu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      thread_en,
  input  logic                      issue,
  input  logic                      mem_read_en,
  input  logic                      mem_write_en,
  input  logic [MEM_ADDR_WIDTH-1:0] addr,
  input  logic [MEM_DATA_WIDTH-1:0] wdata,
  input  logic                      retire,
  output logic [1:0]                lsu_state,
  output logic                      done,
  output logic                      err,
  output logic [MEM_DATA_WIDTH-1:0] rdata,
  input  logic                      read_req_rdy,
  output logic [MEM_ADDR_WIDTH-1:0] read_req_addr,
  output logic                      read_req_addr_val,
  output logic                      read_resp_rdy,
  input  logic [MEM_DATA_WIDTH-1:0] read_resp_data,
  input  logic                      read_resp_data_val,
  input  logic                      write_req_rdy,
  output logic [MEM_ADDR_WIDTH-1:0] write_req_addr,
  output logic [MEM_DATA_WIDTH-1:0] write_req_data,
  output logic                      write_req_val,
  input  logic                      write_resp_val
);

  lsu_state_t                state_q, state_d;
  logic                      is_load_q, is_load_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      req_fire;
  logic                      resp_fire;
  logic                      timeout;

  assign req_fire  = is_load_q ? read_req_rdy : write_req_rdy;
  assign resp_fire = is_load_q ? read_resp_data_val : write_resp_val;

`ifdef LSU_TIMEOUT_EN
  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == LSU_REQUEST) && req_fire),
    .count  (state_q == LSU_WAITING),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      LSU_IDLE: begin
        // Exactly one of read/write must be decoded; anything else is dropped.
        if (issue && thread_en && (mem_read_en ^ mem_write_en)) begin
          state_d   = LSU_REQUEST;
          is_load_d = mem_read_en;
          addr_d    = addr;
          wdata_d   = wdata;
        end
      end
      LSU_REQUEST: begin
        if (req_fire) state_d = LSU_WAITING;
      end
      LSU_WAITING: begin
        if (resp_fire) begin
          state_d = LSU_DONE;
          if (is_load_q) rdata_d = read_resp_data;
        end else if (timeout) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
        end
      end
      LSU_DONE: begin
        if (retire) begin
          state_d = LSU_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LSU_IDLE;
      is_load_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign lsu_state         = state_q;
  assign done              = (state_q == LSU_DONE);
  assign err               = err_q;
  assign rdata             = rdata_q;
  assign read_req_addr     = addr_q;
  assign read_req_addr_val = (state_q == LSU_REQUEST) && is_load_q;
  assign read_resp_rdy     = (state_q == LSU_WAITING) && is_load_q;
  assign write_req_addr    = addr_q;
  assign write_req_data    = wdata_q;
  assign write_req_val     = (state_q == LSU_REQUEST) && !is_load_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu : randomized scoreboard bench for lsu with a memory responder     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lsu;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          thread_en, issue, mem_read_en, mem_write_en, retire;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    lsu_state;
  logic          done, err;
  logic [DW-1:0] rdata;
  logic          read_req_rdy, read_req_addr_val, read_resp_rdy, read_resp_data_val;
  logic [AW-1:0] read_req_addr, write_req_addr;
  logic [DW-1:0] read_resp_data, write_req_data;
  logic          write_req_rdy, write_req_val, write_resp_val;

  always #5 clk = ~clk;

  lsu #(
    .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .thread_en         (thread_en),
    .issue             (issue),
    .mem_read_en       (mem_read_en),
    .mem_write_en      (mem_write_en),
    .addr              (addr),
    .wdata             (wdata),
    .retire            (retire),
    .lsu_state         (lsu_state),
    .done              (done),
    .err               (err),
    .rdata             (rdata),
    .read_req_rdy      (read_req_rdy),
    .read_req_addr     (read_req_addr),
    .read_req_addr_val (read_req_addr_val),
    .read_resp_rdy     (read_resp_rdy),
    .read_resp_data    (read_resp_data),
    .read_resp_data_val(read_resp_data_val),
    .write_req_rdy     (write_req_rdy),
    .write_req_addr    (write_req_addr),
    .write_req_data    (write_req_data),
    .write_req_val     (write_req_val),
    .write_resp_val    (write_resp_val)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Reference model: architectural memory and the last value a load returned.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_last;
  // Memory seen by the controller-side responder.
  logic [DW-1:0] ctl_mem [256];

  typedef struct {
    bit            load;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;
  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int rdy_delay  = 0;
  int resp_delay = 0;
  bit spur_req   = 0;

  // Controller responder: holds rdy low rdy_delay cycles, answers resp_delay cycles after accept.
  initial begin
    int            wcnt, rcnt;
    bit            pend, pload;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    wcnt = 0; rcnt = 0; pend = 0; pload = 0; pa = '0; pd = '0;
    read_req_rdy = 0; write_req_rdy = 0;
    read_resp_data_val = 0; write_resp_val = 0; read_resp_data = '0;
    forever begin
      @(posedge clk); #1;
      read_resp_data_val = 0;
      write_resp_val     = 0;
      read_resp_data     = DW'($urandom);
      read_req_rdy       = 0;
      write_req_rdy      = 0;
      if (!reset) begin
        pend = 0; wcnt = 0;
      end else if (spur_req) begin
        read_resp_data_val = 1;
        read_resp_data     = 16'hDEAD;
        write_resp_val     = 1;
        spur_req           = 0;
      end else if (read_req_addr_val || write_req_val) begin
        if (wcnt < rdy_delay) wcnt++;
        else begin
          read_req_rdy  = read_req_addr_val;
          write_req_rdy = write_req_val;
          pend  = 1;
          pload = read_req_addr_val;
          pa    = read_req_addr_val ? read_req_addr : write_req_addr;
          pd    = write_req_data;
          wcnt  = 0;
          rcnt  = 0;
        end
      end else if (pend) begin
        if (lsu_state != 2'd2) pend = 0;
        else if (rcnt < resp_delay) rcnt++;
        else begin
          if (pload) begin
            read_resp_data_val = 1;
            read_resp_data     = ctl_mem[pa];
          end else begin
            write_resp_val = 1;
            ctl_mem[pa]    = pd;
          end
          pend = 0;
        end
      end
    end
  end

  // Monitor: pops expected requests on handshakes and expected results on done.
  initial begin
    bit            pv, pf, pdone, anyv, fire;
    logic [AW-1:0] pa, cur_a;
    logic [DW-1:0] pdat;
    req_t          r;
    cmp_t          c;
    pv = 0; pf = 0; pdone = 0; pa = '0; pdat = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        pv = 0; pf = 0; pdone = 0;
        continue;
      end
      anyv  = read_req_addr_val || write_req_val;
      fire  = (read_req_addr_val && read_req_rdy) || (write_req_val && write_req_rdy);
      cur_a = read_req_addr_val ? read_req_addr : write_req_addr;
      if (pf) check("val_drop_after_accept", anyv, 0);
      if (pv && anyv) begin
        check("req_addr_stable", cur_a, pa);
        check("req_data_stable", write_req_data, pdat);
      end
      if (lsu_state != 2'd2) check("resp_rdy_outside_wait", read_resp_rdy, 0);
      if (fire) begin
        if (req_q.size() == 0) check("req_unexpected", 1, 0);
        else begin
          r = req_q.pop_front();
          check("req_is_load", read_req_addr_val, r.load);
          check("req_addr", cur_a, r.a);
          if (!r.load) check("req_wdata", write_req_data, r.d);
        end
      end
      if (done && !pdone) begin
        if (cmp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          c = cmp_q.pop_front();
          check("result_rdata", rdata, c.rdata);
          check("result_err", err, c.err);
        end
      end
      pv = anyv && !fire; pf = fire; pa = cur_a; pdat = write_req_data; pdone = done;
    end
  end

  // Called and returns at a negedge.
  task automatic do_op(input bit load, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int rd, input int sd, input bit to, input int hold);
    logic [DW-1:0] exp_rd;
    int            t0, lat, exp_lat;
    bit            seen;
    rdy_delay  = rd;
    resp_delay = to ? 100000 : sd;
    if (load && !to) begin
      exp_rd   = ref_mem[a];
      ref_last = exp_rd;
    end else begin
      if (!load) ref_mem[a] = d;
      exp_rd = ref_last;
    end
    req_q.push_back('{load: load, a: a, d: d});
    cmp_q.push_back('{rdata: exp_rd, err: to});
    thread_en = 1; issue = 1; mem_read_en = load; mem_write_en = !load; addr = a; wdata = d;
    t0 = cyc;
    @(negedge clk);
    // Front-end inputs are junk once the operation is accepted.
    issue = 1'($urandom); thread_en = 1'($urandom); mem_read_en = 1'($urandom);
    mem_write_en = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
    seen = 0; lat = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done) begin
        seen = 1; lat = cyc - t0;
      end else @(negedge clk);
    end
    issue = 0;
    if (!seen) begin
      check("done_reached", 0, 1);
      return;
    end
    exp_lat = to ? (2 + rd + TO) : (3 + rd + sd);
    check("latency", lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_hold", {done, lsu_state}, 3'b111);
    end
    retire = 1;
    @(negedge clk);
    retire = 0;
    check("retire_idle", {lsu_state, err, done}, 4'b0000);
  endtask

  task automatic bad_issue(input string nm, input bit te, input bit re, input bit we);
    bit bad;
    bad = 0;
    thread_en = te; issue = 1; mem_read_en = re; mem_write_en = we;
    addr = AW'($urandom); wdata = DW'($urandom);
    @(negedge clk);
    issue = 0;
    for (int i = 0; i < 3; i++) begin
      if (lsu_state != 2'd0 || read_req_addr_val || write_req_val) bad = 1;
      @(negedge clk);
    end
    check(nm, bad, 0);
  endtask

  initial begin
    logic [DW-1:0] v;
    reset = 0; thread_en = 0; issue = 0; mem_read_en = 0; mem_write_en = 0;
    retire = 0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      ref_mem[i] = v;
      ctl_mem[i] = v;
    end
    ref_mem[8'h12] = 16'hBEEF;
    ctl_mem[8'h12] = 16'hBEEF;
    ref_last = '0;

    repeat (3) @(negedge clk);
    check("rst_state", lsu_state, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_vals", {read_req_addr_val, write_req_val, read_resp_rdy}, 0);
    check("rst_latched", {read_req_addr, write_req_data}, 0);
    reset = 1;
    @(negedge clk);

    do_op(1, 8'h12, 16'h5555, 0, 0, 0, 2);
    check("load_beef", rdata, 16'hBEEF);
    do_op(0, 8'h40, 16'h1234, 3, 0, 0, 1);
    check("store_keeps_rdata", rdata, 16'hBEEF);

    bad_issue("both_en_ignored", 1, 1, 1);
    bad_issue("thread_off_ignored", 0, 1, 0);
    bad_issue("neither_en_ignored", 1, 0, 0);

    do_op(1, 8'h40, 16'h0, 1, 1, 0, 0);
    check("load_back_store", rdata, 16'h1234);

    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 2), 0, $urandom_range(0, 3));
    end

`ifdef LSU_TIMEOUT_EN
    do_op(1, 8'h07, 16'h0, 1, 0, 1, 1);
    check("timeout_keeps_rdata", rdata, ref_last);
`endif

    // Reset while WAITING on a load that is never answered.
    rdy_delay = 0; resp_delay = 100000;
    req_q.push_back('{load: 1'b1, a: 8'h33, d: 16'h0});
    thread_en = 1; issue = 1; mem_read_en = 1; mem_write_en = 0; addr = 8'h33;
    @(negedge clk);
    issue = 0;
    for (int i = 0; i < 10 && lsu_state != 2'd2; i++) @(negedge clk);
    check("reached_waiting", lsu_state, 2);
    #2 reset = 0;
    #1;
    check("async_rst_state", lsu_state, 0);
    check("async_rst_outs", {read_req_addr_val, write_req_val, read_resp_rdy, done, err}, 0);
    check("async_rst_data", {rdata, read_req_addr, write_req_data}, 0);
    @(negedge clk);
    reset = 1;
    ref_last = '0;
    spur_req = 1;
    repeat (3) @(negedge clk);
    check("spurious_resp_state", lsu_state, 0);
    check("spurious_resp_rdata", rdata, 0);

    do_op(1, 8'h12, 16'h0, 0, 0, 0, 0);
    check("scoreboard_drained", req_q.size() + cmp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
